// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_gen
//  Purpose  : Multi-channel programmable soft clock divider. It produces one
//             divided clock and one clock-enable pulse per channel, a
//             common-boundary align pulse and a lock indicator. Ratios can be
//             reloaded at run time, and every reload realigns all channels.
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_gen #(
  parameter int                        NUM_CH      = 2,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DIV_DEFAULT = {8'd4, 8'd2},
  parameter int                        LOCK_CYCLES = 16
) (
  input  logic                       clkin,
  input  logic                       rst_n,
  input  logic [NUM_CH*DIV_W-1:0]    div_i,
  input  logic                       load_i,
  output logic [NUM_CH-1:0]          clk_o,
  output logic [NUM_CH-1:0]          en_o,
  output logic                       align_o,
  output logic                       lock_o
);

  localparam int             LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [0:0] {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  state_t                    state;
  logic [LCW-1:0]            lock_cnt;
  logic [NUM_CH*DIV_W-1:0]   ratio;
  logic                      go;
  logic [NUM_CH-1:0]         en_next;

  // Channels drive valid outputs in the next cycle: either already running,
  // or finishing the last settle cycle. A load always wins and stops them.
  assign go = !load_i &&
              ((state == LOCKED) || (lock_cnt == LOCK_LAST));

  // Lock FSM: settle counter, ratio registers and the registered lock flag.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOCKING;
      lock_cnt <= '0;
      ratio    <= DIV_DEFAULT;
      lock_o   <= 1'b0;
    end else if (load_i) begin
      ratio    <= div_i;
      state    <= LOCKING;
      lock_cnt <= '0;
      lock_o   <= 1'b0;
    end else begin
      case (state)
        LOCKING: begin
          if (lock_cnt == LOCK_LAST) begin
            state  <= LOCKED;
            lock_o <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LCW'(1);
          end
        end
        LOCKED: begin
          lock_o <= 1'b1;
        end
        default: begin
          state  <= LOCKING;
          lock_o <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] n_raw;
      logic [DIV_W-1:0] n_eff;
      logic [DIV_W-1:0] nm1;
      logic [DIV_W-1:0] next_cnt;
      logic [DIV_W-1:0] phase;

      // A ratio of 0 behaves exactly like a ratio of 1.
      assign n_raw    = ratio[c*DIV_W +: DIV_W];
      assign n_eff    = (n_raw == '0) ? DIV_W'(1) : n_raw;
      assign nm1      = n_eff - DIV_W'(1);
      assign next_cnt = (cnt == nm1) ? '0 : cnt + DIV_W'(1);
      // First locked cycle shows phase 0; afterwards the look-ahead count.
      assign phase    = (state == LOCKED) ? next_cnt : '0;
      assign en_next[c] = go && (phase == nm1);

      // Per-channel phase counter with registered clock and enable outputs.
      always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
          cnt      <= '0;
          clk_o[c] <= 1'b0;
          en_o[c]  <= 1'b0;
        end else if (go) begin
          cnt      <= phase;
          clk_o[c] <= (phase < (n_eff >> 1));
          en_o[c]  <= (phase == nm1);
        end else begin
          cnt      <= '0;
          clk_o[c] <= 1'b0;
          en_o[c]  <= 1'b0;
        end
      end
    end
  endgenerate

  // Align pulse registered from the same look-ahead enables as en_o.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      align_o <= 1'b0;
    end else begin
      align_o <= &en_next;
    end
  end

endmodule
`default_nettype wire
